// File: rtl/bpc_pkg.sv
// Shared constants and types for the bit-plane compression ZRLE stage:
// block geometry, prefix-code lengths and prefixes, and the encoder FSM states.
package bpc_pkg;

    localparam int SYM_PER_BLK  = 16;
    localparam int BEAT_PER_BLK = 8;
    localparam int BLK_BITS     = 512;
    localparam int ACC_W        = 130;
    localparam int CODE_W       = 66;

    // The reserved 2-bit header 2'b00 occupies the first bits of every block.
    localparam logic [7:0] HDR_BITS = 8'd2;

    localparam logic [6:0] LEN_ZERO  = 7'd6;
    localparam logic [6:0] LEN_W0    = 7'd22;
    localparam logic [6:0] LEN_ONE   = 7'd21;
    localparam logic [6:0] LEN_TWO   = 7'd36;
    localparam logic [6:0] LEN_THREE = 7'd52;
    localparam logic [6:0] LEN_FOUR  = 7'd66;

    localparam logic [5:0] PFX_ZERO  = 6'b000000;
    localparam logic [5:0] PFX_W0    = 6'b000001;
    localparam logic [4:0] PFX_W1    = 5'b00001;
    localparam logic [4:0] PFX_W2    = 5'b00010;
    localparam logic [4:0] PFX_W3    = 5'b00011;
    localparam logic [3:0] PFX_W1W0  = 4'b0010;
    localparam logic [3:0] PFX_W2W0  = 4'b0011;
    localparam logic [3:0] PFX_W3W0  = 4'b0100;
    localparam logic [3:0] PFX_W2W1  = 4'b0101;
    localparam logic [3:0] PFX_W3W1  = 4'b0110;
    localparam logic [3:0] PFX_W3W2  = 4'b0111;
    localparam logic [3:0] PFX_NO_W3 = 4'b1000;
    localparam logic [3:0] PFX_NO_W2 = 4'b1001;
    localparam logic [3:0] PFX_NO_W1 = 4'b1010;
    localparam logic [3:0] PFX_NO_W0 = 4'b1011;
    localparam logic [1:0] PFX_FOUR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/zrle_code_gen.sv
// Combinational ZRLE code generator: one 64-bit symbol to a left-aligned
// prefix code (prefix followed by the nonzero 16-bit words, high to low).
module zrle_code_gen
    import bpc_pkg::*;
(
    input  logic [63:0]       data_i,
    output logic [CODE_W-1:0] code_o,
    output logic [6:0]        len_o
);

    logic [15:0] w3, w2, w1, w0;
    logic [3:0]  nz;

    assign w3 = data_i[63:48];
    assign w2 = data_i[47:32];
    assign w1 = data_i[31:16];
    assign w0 = data_i[15:0];
    assign nz = {|w3, |w2, |w1, |w0};

    // NOTE: both outputs get a default first so no path through the case infers a latch.
    always_comb begin
        code_o = '0;
        len_o  = LEN_ZERO;
        case (nz)
            4'b0000: begin code_o = {PFX_ZERO, 60'd0};              len_o = LEN_ZERO;  end
            4'b0001: begin code_o = {PFX_W0, w0, 44'd0};            len_o = LEN_W0;    end
            4'b0010: begin code_o = {PFX_W1, w1, 45'd0};            len_o = LEN_ONE;   end
            4'b0100: begin code_o = {PFX_W2, w2, 45'd0};            len_o = LEN_ONE;   end
            4'b1000: begin code_o = {PFX_W3, w3, 45'd0};            len_o = LEN_ONE;   end
            4'b0011: begin code_o = {PFX_W1W0, w1, w0, 30'd0};      len_o = LEN_TWO;   end
            4'b0101: begin code_o = {PFX_W2W0, w2, w0, 30'd0};      len_o = LEN_TWO;   end
            4'b1001: begin code_o = {PFX_W3W0, w3, w0, 30'd0};      len_o = LEN_TWO;   end
            4'b0110: begin code_o = {PFX_W2W1, w2, w1, 30'd0};      len_o = LEN_TWO;   end
            4'b1010: begin code_o = {PFX_W3W1, w3, w1, 30'd0};      len_o = LEN_TWO;   end
            4'b1100: begin code_o = {PFX_W3W2, w3, w2, 30'd0};      len_o = LEN_TWO;   end
            4'b0111: begin code_o = {PFX_NO_W3, w2, w1, w0, 14'd0}; len_o = LEN_THREE; end
            4'b1011: begin code_o = {PFX_NO_W2, w3, w1, w0, 14'd0}; len_o = LEN_THREE; end
            4'b1101: begin code_o = {PFX_NO_W1, w3, w2, w0, 14'd0}; len_o = LEN_THREE; end
            4'b1110: begin code_o = {PFX_NO_W0, w3, w2, w1, 14'd0}; len_o = LEN_THREE; end
            default: begin code_o = {PFX_FOUR, data_i};             len_o = LEN_FOUR;  end
        endcase
    end

endmodule

// File: rtl/zrle_comp.sv
// ZRLE encoder: packs 16 prefix-coded symbols per block MSB-first into
// exactly 8 64-bit beats behind a 2-bit header, dropping codes that overflow.
module zrle_comp
    import bpc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [63:0] data_i,
    input  logic        sop_i,
    input  logic        eop_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [63:0] data_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic        ovf_o,
    input  logic        ready_i
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_pp;
    logic [7:0]         fill_q, fill_d, fill_pp;
    logic [9:0]         blk_bits_q, blk_bits_d;
    logic [3:0]         sym_cnt_q, sym_cnt_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic               ovf_q, ovf_d;
    logic [CODE_W-1:0]  code;
    logic [6:0]         len;
    logic [10:0]        bits_after;
    logic               pop, accept, drop;
    logic               unused_framing;

    // Framing follows sym_cnt; the markers are only checked by the environment.
    assign unused_framing = sop_i ^ eop_i;

    zrle_code_gen u_code_gen (
        .data_i (data_i),
        .code_o (code),
        .len_o  (len)
    );

    assign valid_o    = (state_q == ST_RUN && fill_q >= 8'd64) || state_q == ST_FLUSH;
    assign pop        = valid_o & ready_i;
    assign fill_pp    = !pop ? fill_q : (fill_q >= 8'd64) ? fill_q - 8'd64 : 8'd0;
    assign acc_pp     = pop ? acc_q << 64 : acc_q;
    assign ready_o    = (state_q == ST_RUN) && (fill_pp < 8'd64);
    assign accept     = valid_i & ready_o;
    assign bits_after = {1'b0, blk_bits_q} + {4'd0, len};
    assign drop       = ovf_q || (bits_after > 11'(BLK_BITS));

    assign data_o = acc_q[ACC_W-1 -: 64];
    assign sop_o  = valid_o && beat_cnt_q == 4'd0;
    assign eop_o  = valid_o && beat_cnt_q == 4'(BEAT_PER_BLK - 1);
    assign ovf_o  = eop_o && ovf_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_pp;
        fill_d     = fill_pp;
        blk_bits_d = blk_bits_q;
        sym_cnt_d  = sym_cnt_q;
        beat_cnt_d = beat_cnt_q + {3'd0, pop};
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                acc_d      = '0;
                fill_d     = HDR_BITS;
                blk_bits_d = {2'd0, HDR_BITS};
                sym_cnt_d  = '0;
                beat_cnt_d = '0;
                ovf_d      = 1'b0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    sym_cnt_d = sym_cnt_q + 4'd1;
                    if (drop) begin
                        ovf_d = 1'b1;
                    end else begin
                        // Append after any pop of this cycle, at the post-pop fill.
                        acc_d      = acc_pp | ({code, 64'd0} >> fill_pp);
                        fill_d     = fill_pp + {1'b0, len};
                        blk_bits_d = bits_after[9:0];
                    end
                    if (sym_cnt_q == 4'(SYM_PER_BLK - 1)) begin
                        state_d = (beat_cnt_d == 4'(BEAT_PER_BLK)) ? ST_IDLE : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && beat_cnt_q == 4'(BEAT_PER_BLK - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            fill_q     <= HDR_BITS;
            blk_bits_q <= {2'd0, HDR_BITS};
            sym_cnt_q  <= '0;
            beat_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            blk_bits_q <= blk_bits_d;
            sym_cnt_q  <= sym_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_zrle_comp.sv
// Self-checking bench for zrle_comp: directed and random blocks compared
// against a bit-string reference encoder and a golden decoder.
module tb_zrle_comp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, sop_i, eop_i, ready_i;
    logic [63:0] data_i;
    logic        ready_o, valid_o, sop_o, eop_o, ovf_o;
    logic [63:0] data_o;

    int n_vec = 0;
    int n_err = 0;

    zrle_comp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .data_i  (data_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .ovf_o   (ovf_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the block as a 512-bit string filled MSB-first.
    logic [63:0]  syms [16];
    logic [63:0]  rx [8];
    logic         rx_ovf;
    logic [511:0] m_blk;
    int           m_pos, m_kept;
    logic         m_ovf;
    int           d_pos;

    task automatic m_put(input logic [15:0] v, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            m_blk[511 - m_pos] = v[b];
            m_pos++;
        end
    endtask

    task automatic model_encode();
        logic [15:0] w [4];
        int n, pfx, plen, len, idx;
        m_blk = '0; m_pos = 2; m_ovf = 1'b0; m_kept = 0;
        for (int s = 0; s < 16; s++) begin
            n = 0; pfx = 0; plen = 0; idx = 0;
            for (int j = 0; j < 4; j++) begin
                w[j] = syms[s][16*j +: 16];
                if (w[j] != 16'd0) n++;
            end
            case (n)
                0: begin pfx = 0; plen = 6; end
                1: begin
                    for (int j = 0; j < 4; j++) if (w[j] != 16'd0) pfx = j;
                    if (pfx == 0) begin pfx = 1; plen = 6; end else plen = 5;
                end
                2: begin
                    for (int lo = 0; lo < 3; lo++)
                        for (int hi = lo + 1; hi < 4; hi++) begin
                            if (w[lo] != 16'd0 && w[hi] != 16'd0) pfx = 2 + idx;
                            idx++;
                        end
                    plen = 4;
                end
                3: begin
                    for (int j = 0; j < 4; j++) if (w[j] == 16'd0) pfx = 8 + (3 - j);
                    plen = 4;
                end
                default: begin pfx = 3; plen = 2; end
            endcase
            len = plen + 16 * n;
            if (m_ovf || m_pos + len > 512) begin
                m_ovf = 1'b1;
            end else begin
                m_put(16'(pfx), plen);
                for (int j = 3; j >= 0; j--) if (w[j] != 16'd0) m_put(w[j], 16);
                m_kept++;
            end
        end
    endtask

    task automatic rd(input logic [511:0] blk, input int n, output logic [15:0] v);
        v = '0;
        for (int b = 0; b < n; b++) begin
            v = {v[14:0], blk[511 - d_pos]};
            d_pos++;
        end
    endtask

    task automatic decode_and_check(input logic [511:0] blk, input int nsym);
        logic [15:0] v, b;
        logic [15:0] w [4];
        int code, idx, hi_w, lo_w;
        d_pos = 2;
        for (int s = 0; s < nsym; s++) begin
            for (int j = 0; j < 4; j++) w[j] = 16'd0;
            rd(blk, 2, v);
            code = int'(v);
            if (code == 3) begin
                for (int j = 3; j >= 0; j--) rd(blk, 16, w[j]);
            end else begin
                rd(blk, 2, b);
                code = code * 4 + int'(b);
                if (code >= 8) begin
                    for (int j = 3; j >= 0; j--) if (j != 3 - (code - 8)) rd(blk, 16, w[j]);
                end else if (code >= 2) begin
                    idx = 0; hi_w = 0; lo_w = 0;
                    for (int lo = 0; lo < 3; lo++)
                        for (int hi = lo + 1; hi < 4; hi++) begin
                            if (idx == code - 2) begin hi_w = hi; lo_w = lo; end
                            idx++;
                        end
                    rd(blk, 16, w[hi_w]);
                    rd(blk, 16, w[lo_w]);
                end else begin
                    rd(blk, 1, b);
                    code = code * 2 + int'(b);
                    if (code != 0) begin
                        rd(blk, 16, w[code]);
                    end else begin
                        rd(blk, 1, b);
                        if (b[0]) rd(blk, 16, w[0]);
                    end
                end
            end
            check($sformatf("dec_sym%0d", s), {w[3], w[2], w[1], w[0]}, syms[s]);
        end
    endtask

    task automatic drive_syms(input int nsym);
        logic hs;
        int guard;
        for (int i = 0; i < nsym; i++) begin
            hs = 1'b0; guard = 0;
            while (!hs) begin
                @(negedge clk);
                valid_i = 1'b1; data_i = syms[i];
                sop_i = (i == 0); eop_i = (i == 15);
                #2 hs = ready_o;
                guard++;
                if (!hs && guard > 300) begin
                    check("drv_timeout", 64'd1, 64'd0);
                    valid_i = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    endtask

    task automatic collect(input logic stall);
        int nb, stalls, guard;
        logic [63:0] held;
        nb = 0; stalls = 0; guard = 0; held = '0; rx_ovf = 1'b0;
        while (nb < 8) begin
            @(negedge clk);
            ready_i = !(stall && nb == 3 && stalls < 5);
            #2;
            if (valid_o) begin
                if (!ready_i) begin
                    if (stalls == 0) held = data_o;
                    else check("stall_hold", data_o, held);
                    check("stall_ready_o", 64'(ready_o), 64'd0);
                    stalls++;
                end else begin
                    rx[nb] = data_o;
                    check($sformatf("sop_b%0d", nb), 64'(sop_o), 64'(nb == 0));
                    check($sformatf("eop_b%0d", nb), 64'(eop_o), 64'(nb == 7));
                    if (nb == 7) begin
                        rx_ovf = ovf_o;
                        check("ovf_eop", 64'(ovf_o), 64'(m_ovf));
                    end
                    nb++;
                end
            end
            guard++;
            if (guard > 400) begin
                check("mon_timeout", 64'd1, 64'd0);
                ready_i = 1'b1;
                return;
            end
        end
        ready_i = 1'b1;
    endtask

    task automatic run_block(input logic stall);
        model_encode();
        fork
            drive_syms(16);
            collect(stall);
        join
        for (int i = 0; i < 8; i++)
            check($sformatf("beat%0d", i), rx[i], m_blk[511 - 64*i -: 64]);
        if (stall)
            decode_and_check({rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], rx[6], rx[7]}, m_kept);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid_o"}, 64'(valid_o), 64'd0);
        check({tag, "_sop_o"},   64'(sop_o),   64'd0);
        check({tag, "_eop_o"},   64'(eop_o),   64'd0);
        check({tag, "_ovf_o"},   64'(ovf_o),   64'd0);
        check({tag, "_data_o"},  data_o,       64'd0);
        check({tag, "_ready_o"}, 64'(ready_o), 64'd0);
    endtask

    task automatic rand_syms(input int density);
        for (int s = 0; s < 16; s++)
            for (int j = 0; j < 4; j++)
                syms[s][16*j +: 16] = ($urandom_range(0, 99) < density) ? 16'($urandom) : 16'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
        data_i = '0; ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #2 check_outputs_zero("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1 check("post_rst_ready_o", 64'(ready_o), 64'd1);

        for (int s = 0; s < 16; s++) syms[s] = 64'd0;
        run_block(1'b0);
        check("zero_beat0", rx[0], 64'd0);
        check("zero_ovf", 64'(rx_ovf), 64'd0);

        syms[0] = 64'h0000_0000_0000_ABCD;
        run_block(1'b0);
        check("w0_beat0", rx[0], 64'h01AB_CD00_0000_0000);
        check("w0_beat1", rx[1], 64'd0);

        syms[0] = 64'h0000_0000_1234_0000;
        run_block(1'b0);
        check("w1_beat0", rx[0], 64'h0224_6800_0000_0000);

        for (int s = 0; s < 16; s++) syms[s] = '1;
        run_block(1'b0);
        check("ones_beat0", rx[0], 64'h3FFF_FFFF_FFFF_FFFF);
        check("ones_ovf", 64'(rx_ovf), 64'd1);

        for (int b = 0; b < 16; b++) begin
            rand_syms((b % 4 == 3) ? 90 : 40);
            run_block(b % 3 == 0);
        end

        rand_syms(50);
        model_encode();
        drive_syms(6);
        @(negedge clk) rst_n = 1'b0;
        #2 check_outputs_zero("midrst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1 check("midrst_ready_o", 64'(ready_o), 64'd1);
        run_block(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
